interval_timer_scheduler: RTL

- Shares one CNT_W-bit cycle counter among NUM_REQ requesters. Each requester needs a timed interval.
- Requesters present a duration and assert req. A round-robin arbiter grants one requester at a time.
- The block clears and runs the counter until the latched duration is reached, then pulses done to the owner.
- Sits between client FSMs (debounce, display refresh, delays) and the shared timing resource.

---
 rtl/interval_timer_scheduler_pkg.sv | 12 +
 rtl/rr_arbiter_pick.sv | 27 ++
 rtl/interval_timer_scheduler.sv | 124 ++++++++++++
 3 files changed

// File: rtl/interval_timer_scheduler_pkg.sv
// Shared definitions for the interval timer scheduler: FSM encoding and default counter width.
package interval_timer_scheduler_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick: first set request bit searching upward from ptr, with wrap.
module rr_arbiter_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] probe;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    probe = '0;
    for (int i = 0; i < N; i++) begin
      probe = IDX_W'((int'(ptr) + i) % N);
      if (!valid && req[probe]) begin
        idx   = probe;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interval_timer_scheduler.sv
// Shares one cycle counter among NUM_REQ requesters; round-robin grant, run to latched
// duration, then a one-cycle done pulse to the owner. All outputs are registered.
module interval_timer_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = interval_timer_scheduler_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] dur,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         elapsed
);
  import interval_timer_scheduler_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   owner, owner_nx;
  logic [IDX_W-1:0]   rr_ptr, ptr_nx;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;
  logic [CNT_W-1:0]   dur_l, dur_nx;
  logic [CNT_W-1:0]   count, count_nx;
  logic [NUM_REQ-1:0] grant_nx, done_nx;
  logic               busy_nx;
  logic               abort, at_end;
  logic [IDX_W-1:0]   ptr_after;

  rr_arbiter_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (win_idx),
    .valid (win_valid)
  );

  // Abort is checked before completion so a dropped req never yields done.
  assign abort     = !req[owner];
  assign at_end    = (count == dur_l);
  assign ptr_after = IDX_W'((int'(owner) + 1) % NUM_REQ);
  assign elapsed   = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      dur_l  <= '0;
      count  <= '0;
      grant  <= '0;
      done   <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      rr_ptr <= ptr_nx;
      dur_l  <= dur_nx;
      count  <= count_nx;
      grant  <= grant_nx;
      done   <= done_nx;
      busy   <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (win_valid) state_nx = S_RUN;
      S_RUN: begin
        if (abort)       state_nx = S_IDLE;
        else if (at_end) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    owner_nx = owner;
    ptr_nx   = rr_ptr;
    dur_nx   = dur_l;
    count_nx = count;
    grant_nx = grant;
    done_nx  = '0;
    busy_nx  = busy;
    case (state)
      S_IDLE: begin
        count_nx = '0;
        if (win_valid) begin
          owner_nx = win_idx;
          dur_nx   = dur[win_idx*CNT_W +: CNT_W];
          grant_nx = NUM_REQ'(1) << win_idx;
          busy_nx  = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          grant_nx = '0;
          busy_nx  = 1'b0;
          count_nx = '0;
          ptr_nx   = ptr_after;
        end else if (at_end) begin
          done_nx = NUM_REQ'(1) << owner;
        end else begin
          count_nx = count + CNT_W'(1);
        end
      end
      S_DONE: begin
        grant_nx = '0;
        busy_nx  = 1'b0;
        count_nx = '0;
        ptr_nx   = ptr_after;
      end
      default: begin
        grant_nx = '0;
        busy_nx  = 1'b0;
        count_nx = '0;
      end
    endcase
  end

endmodule
